// File: rtl/mole_round_engine_pkg.sv
// mole_round_engine_pkg: shared FSM encoding, LFSR step and level mapping for the mole round engine
package mole_round_engine_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GAP = 2'd1, ST_UP = 2'd2} state_e;
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction
  function automatic logic [1:0] level_for(input int s, input int l1, input int l2, input int l3);
    return s >= l3 ? 2'd3 : s >= l2 ? 2'd2 : s >= l1 ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mole_round_engine_lfsr.sv
// mole_round_engine_lfsr: free-running 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1), loads seed on reset
module mole_round_engine_lfsr
  import mole_round_engine_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  // steps every cycle; a nonzero seed keeps it out of the all-zero lock-up state
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= seed;
    else q <= lfsr_next(q);
endmodule

// File: rtl/mole_round_engine.sv
// mole_round_engine: whack-a-mole round FSM picking a random mole, timing its up-time and scoring presses
module mole_round_engine
  import mole_round_engine_pkg::*;
#(
  parameter int         N_MOLES    = 3,
  parameter int         IDX_W      = 4,
  parameter int         SCORE_W    = 8,
  parameter int         CNT_W      = 28,
  parameter int         GAP_CYCLES = 150_000_000,
  parameter int         UP_L0      = 200_000_000,
  parameter int         UP_L1      = 100_000_000,
  parameter int         UP_L2      = 50_000_000,
  parameter int         UP_L3      = 25_000_000,
  parameter int         LVL1_SCORE = 3,
  parameter int         LVL2_SCORE = 6,
  parameter int         LVL3_SCORE = 11,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               game,
  input  logic [N_MOLES-1:0] button,
  output logic [N_MOLES-1:0] mole_onehot,
  output logic               mole_valid,
  output logic [IDX_W-1:0]   mole_index,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         level,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               timeout_pulse
);
  localparam logic [CNT_W-1:0]   GAP_T     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  state_e             state;
  logic [CNT_W-1:0]   timer;
  logic [CNT_W-1:0]   up_time;
  logic [N_MOLES-1:0] button_q;
  logic [N_MOLES-1:0] edge_b;
  logic [7:0]         lfsr;
  logic [IDX_W-1:0]   pick;
  logic [1:0]         next_level;
  logic               hit;
  logic               wrong;
  mole_round_engine_lfsr u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );
  assign mole_valid = |mole_onehot;
  // rising edges only, classified against the mole that is currently up
  always_comb begin
    edge_b     = button & ~button_q;
    hit        = |(edge_b & mole_onehot);
    wrong      = |(edge_b & ~mole_onehot);
    pick       = IDX_W'(lfsr % 8'(N_MOLES));
    next_level = level_for(int'(score), LVL1_SCORE, LVL2_SCORE, LVL3_SCORE);
    up_time    = next_level == 2'd3 ? CNT_W'(UP_L3 - 1) :
                 next_level == 2'd2 ? CNT_W'(UP_L2 - 1) :
                 next_level == 2'd1 ? CNT_W'(UP_L1 - 1) : CNT_W'(UP_L0 - 1);
  end
  // round FSM: gap timer, mole selection, scoring and one-cycle result pulses
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      button_q      <= '0;
      mole_onehot   <= '0;
      mole_index    <= '0;
      score         <= '0;
      level         <= '0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      button_q      <= button;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      if (!game) begin
        state       <= ST_IDLE;
        timer       <= '0;
        mole_onehot <= '0;
        mole_index  <= '0;
        score       <= '0;
        level       <= '0;
      end else
        case (state)
          ST_IDLE: begin
            state <= ST_GAP;
            timer <= GAP_T;
          end
          ST_GAP:
            if (timer == '0) begin
              state       <= ST_UP;
              mole_index  <= pick;
              mole_onehot <= N_MOLES'(1) << pick;
              level       <= next_level;
              timer       <= up_time;
            end else timer <= timer - 1'b1;
          ST_UP: begin
            // a miss on the final up cycle holds the timer at zero so the timeout lands next cycle
            timer <= timer == '0 ? timer : timer - 1'b1;
            if (hit) begin
              score       <= score == SCORE_MAX ? score : score + 1'b1;
              hit_pulse   <= 1'b1;
              mole_onehot <= '0;
              state       <= ST_GAP;
              timer       <= GAP_T;
            end else if (wrong) begin
              score      <= score == '0 ? score : score - 1'b1;
              miss_pulse <= 1'b1;
            end else if (timer == '0) begin
              timeout_pulse <= 1'b1;
              mole_onehot   <= '0;
              state         <= ST_GAP;
              timer         <= GAP_T;
            end
          end
          default: state <= ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mole_round_engine.sv
// tb_mole_round_engine: randomized and directed checks of the round engine against a phase-count model
module tb_mole_round_engine;
  localparam int GAP = 4;
  localparam int L1 = 2, L2 = 4, L3 = 6;
  int up_len[4] = '{8, 6, 4, 2};
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       game = 1'b0;
  logic [2:0] button = 3'b000;
  logic [2:0] mole_onehot;
  logic       mole_valid;
  logic [3:0] mole_index;
  logic [3:0] score;
  logic [1:0] level;
  logic       hit_pulse, miss_pulse, timeout_pulse;
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_left = 0, m_score = 0, m_level = 0, m_idx = 0;
  bit m_up = 0, m_hit = 0, m_miss = 0, m_to = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [2:0] m_prev = 3'b000;

  mole_round_engine #(
    .N_MOLES(3), .IDX_W(4), .SCORE_W(4), .CNT_W(8), .GAP_CYCLES(GAP),
    .UP_L0(8), .UP_L1(6), .UP_L2(4), .UP_L3(2),
    .LVL1_SCORE(L1), .LVL2_SCORE(L2), .LVL3_SCORE(L3), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock), .reset(reset), .game(game), .button(button),
    .mole_onehot(mole_onehot), .mole_valid(mole_valid), .mole_index(mole_index),
    .score(score), .level(level), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clock = ~clock;

  function automatic int lvl_of(input int s);
    return s >= L3 ? 3 : s >= L2 ? 2 : s >= L1 ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_score = 0; m_level = 0; m_idx = 0;
    m_up = 0; m_hit = 0; m_miss = 0; m_to = 0;
    m_lfsr = 8'hA5; m_prev = 3'b000;
  endtask

  task automatic model_step();
    logic [2:0] e;
    logic [7:0] cur;
    e = button & ~m_prev;
    m_prev = button;
    cur = m_lfsr;
    m_lfsr = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    m_hit = 0; m_miss = 0; m_to = 0;
    if (!game) begin
      m_mode = 0; m_score = 0; m_level = 0; m_up = 0; m_idx = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_left = GAP;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 2; m_up = 1; m_idx = int'(cur) % 3;
        m_level = lvl_of(m_score); m_left = up_len[m_level];
      end
    end else if (e[m_idx]) begin
      m_hit = 1; m_score = m_score == 15 ? 15 : m_score + 1;
      m_up = 0; m_mode = 1; m_left = GAP;
    end else if (e != 3'b000) begin
      m_miss = 1;
      if (m_score > 0) m_score--;
      if (m_left > 1) m_left--;
    end else if (m_left == 1) begin
      m_to = 1; m_up = 0; m_mode = 1; m_left = GAP;
    end else m_left--;
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    logic [16:0] act, exp;
    @(negedge clock);
    exp = {m_up ? 3'b001 << m_idx : 3'b000, m_up, 4'(m_idx), 4'(m_score), 2'(m_level), m_hit, m_miss, m_to};
    act = {mole_onehot, mole_valid, mole_index, score, level, hit_pulse, miss_pulse, timeout_pulse};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL outputs t=%0t got %h expected %h", $time, act, exp);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_up();
    int k = 0;
    while (m_up && k < 50) begin cyc(1); k++; end
    while (!m_up && k < 50) begin cyc(1); k++; end
    if (!m_up) chk("wait_up_timeout", 0, 1);
  endtask

  task automatic hit(input int d);
    wait_up();
    cyc(d);
    button = 3'b001 << m_idx;
    cyc(1);
    chk("hit_pulse", int'(hit_pulse), 1);
    button = 3'b000;
  endtask

  initial begin
    int n, w;
    cyc(3);
    chk("reset_score", int'(score), 0);
    chk("reset_valid", int'(mole_valid), 0);
    reset = 1'b0; game = 1'b1;
    cyc(4);
    chk("gap_no_mole", int'(mole_valid), 0);
    cyc(1);
    chk("first_valid", int'(mole_valid), 1);
    chk("first_onehot", int'(mole_onehot), 1);
    chk("first_index", int'(mole_index), 0);
    cyc(7);
    chk("still_up", int'(mole_valid), 1);
    cyc(1);
    chk("timeout_pulse", int'(timeout_pulse), 1);
    chk("timeout_cleared", int'(mole_valid), 0);
    chk("timeout_score", int'(score), 0);
    cyc(1);
    chk("timeout_one_cycle", int'(timeout_pulse), 0);
    hit(2);
    chk("hit1_score", int'(score), 1);
    chk("hit1_cleared", int'(mole_onehot), 0);
    hit(2);
    chk("hit2_score", int'(score), 2);
    wait_up();
    chk("level1", int'(level), 1);
    n = 0;
    while (mole_valid && n < 20) begin n++; cyc(1); end
    chk("level1_uptime", n, 6);
    wait_up();
    w = (m_idx + 1) % 3;
    button = 3'b001 << w; cyc(1);
    chk("miss1_pulse", int'(miss_pulse), 1);
    chk("miss1_score", int'(score), 1);
    chk("miss1_stays", int'(mole_valid), 1);
    button = 3'b000; cyc(1);
    button = 3'b001 << w; cyc(1);
    chk("miss2_score", int'(score), 0);
    button = 3'b000; cyc(1);
    button = 3'b001 << w; cyc(1);
    chk("miss_floor_pulse", int'(miss_pulse), 1);
    chk("miss_floor_score", int'(score), 0);
    button = 3'b000;
    wait_up();
    button = 3'b111; cyc(1);
    chk("both_hit", int'(hit_pulse), 1);
    chk("both_no_miss", int'(miss_pulse), 0);
    chk("both_score", int'(score), 1);
    button = 3'b000;
    n = 0;
    while (m_score < 15 && n < 30) begin hit(0); n++; end
    hit(0);
    chk("sat_score", int'(score), 15);
    button = 3'b111;
    wait_up();
    n = 0;
    while (!timeout_pulse && n < 20) begin cyc(1); n++; end
    chk("held_timeout", int'(timeout_pulse), 1);
    chk("held_score", int'(score), 15);
    button = 3'b000;
    wait_up();
    cyc(1);
    game = 1'b0; cyc(1);
    chk("drop_valid", int'(mole_valid), 0);
    chk("drop_score", int'(score), 0);
    game = 1'b1; cyc(2);
    reset = 1'b1; #1;
    chk("rst_valid", int'(mole_valid), 0);
    chk("rst_lfsr", int'(dut.u_lfsr.q), 8'hA5);
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      cyc(1);
      r = $urandom_range(0, 7);
      button = r < 3 ? 3'b000 : r < 5 ? 3'b001 << m_idx : 3'($urandom);
      game = $urandom_range(0, 299) != 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
